anvil_bus_arbiter: RTL and testbench

Two-master to one-slave bus arbiter placed directly downstream of the anvil core. It merges the core's instruction port (i_*) and data port (d_*) onto a single valid/ready memory port (m_*), so the core can run from one unified memory. Requests are registered, arbitrated round-robin when both ports are pending, and answered with a one-cycle registered ready pulse carrying the read data.

---
 rtl/anvil_bus_arbiter.sv | 116 +++++++++++
 tb/tb_anvil_bus_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/anvil_bus_arbiter.sv
// Merges the core's instruction and data ports onto one valid/ready memory port, round-robin on ties.
// Latency: grant 1 cycle after valid, ready pulse 1 cycle after m_ready; one access in flight, 3-cycle minimum.
module anvil_bus_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_wstrb,
  output logic              i_ready,
  output logic [31:0]       i_rdata,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wstrb,
  output logic              d_ready,
  output logic [31:0]       d_rdata,
  output logic              m_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  output logic [3:0]        m_wstrb,
  input  logic              m_ready,
  input  logic [31:0]       m_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e            state_q;
  logic              owner_q;
  logic              last_q;
  logic              m_valid_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [31:0]       m_wdata_q;
  logic [3:0]        m_wstrb_q;
  logic              i_ready_q;
  logic              d_ready_q;
  logic [31:0]       i_rdata_q;
  logic [31:0]       d_rdata_q;
  logic              gnt_d;

  // Instruction write fields are tied off by the core and never forwarded.
  logic unused_ok;
  assign unused_ok = ^{i_wdata, i_wstrb};

  // 1 = data port wins; on a tie the master not served last time wins.
  assign gnt_d = (i_valid && d_valid) ? ~last_q : d_valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_valid || d_valid) begin
            m_valid_q <= 1'b1;
            owner_q   <= gnt_d;
            last_q    <= gnt_d;
            state_q   <= BUSY;
            if (gnt_d) begin
              m_addr_q  <= d_addr;
              m_wdata_q <= d_wdata;
              m_wstrb_q <= d_wstrb;
            end else begin
              m_addr_q  <= i_addr;
              m_wdata_q <= '0;
              m_wstrb_q <= '0;
            end
          end
        end
        BUSY: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            m_wstrb_q <= '0;
            state_q   <= RESP;
            if (owner_q) begin
              d_ready_q <= 1'b1;
              d_rdata_q <= m_rdata;
            end else begin
              i_ready_q <= 1'b1;
              i_rdata_q <= m_rdata;
            end
          end
        end
        RESP: begin
          // Gap cycle so the master can drop valid before IDLE samples it again.
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_valid = m_valid_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;
  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_anvil_bus_arbiter.sv
// Directed bench for anvil_bus_arbiter: expected accesses queued at drive time, checked as memory serves them.
module tb_anvil_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        i_valid, d_valid, m_ready;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata, m_rdata;
  logic [3:0]  i_wstrb, d_wstrb;
  logic        i_ready, d_ready, m_valid;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_wstrb;

  always #5 clk = ~clk;

  anvil_bus_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rdata(m_rdata)
  );

  typedef struct packed {
    logic        is_d;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] i_rd_exp = '0;
  logic [31:0] d_rd_exp = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic push_i(input logic [31:0] a, input logic [31:0] rd);
    exp_t e;
    i_valid = 1'b1; i_addr = a;
    e = '{is_d: 1'b0, addr: a, wdata: 32'h0, wstrb: 4'h0, rdata: rd};
    sb.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] rd);
    exp_t e;
    d_valid = 1'b1; d_addr = a; d_wdata = wd; d_wstrb = ws;
    e = '{is_d: 1'b1, addr: a, wdata: wd, wstrb: ws, rdata: rd};
    sb.push_back(e);
  endtask

  // Called at a negedge; plays the memory for the oldest expected access.
  task automatic serve(input string tag, input int waits, input bit mutate);
    exp_t e;
    int   n;
    n = 0;
    while (m_valid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_grant_lat"}, n, 1);
    if (m_valid !== 1'b1) return;
    chk({tag, "_sb_nonempty"}, (sb.size() > 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, "_addr"}, m_addr, e.addr);
    chk({tag, "_wdata"}, m_wdata, e.wdata);
    chk({tag, "_wstrb"}, m_wstrb, {28'h0, e.wstrb});
    for (int w = 0; w < waits; w++) begin
      if (mutate) begin
        d_addr = ~d_addr; d_wdata = ~d_wdata; d_valid = 1'b0;
      end
      @(negedge clk);
      chk({tag, "_hold_valid"}, m_valid, 1);
      chk({tag, "_hold_addr"}, m_addr, e.addr);
      chk({tag, "_hold_wdata"}, m_wdata, e.wdata);
      chk({tag, "_hold_wstrb"}, m_wstrb, {28'h0, e.wstrb});
      chk({tag, "_hold_rdy"}, {i_ready, d_ready}, 0);
    end
    m_ready = 1'b1; m_rdata = e.rdata;
    @(negedge clk);
    m_ready = 1'b0; m_rdata = $urandom;
    if (e.is_d) d_rd_exp = e.rdata; else i_rd_exp = e.rdata;
    chk({tag, "_mvalid_drop"}, m_valid, 0);
    chk({tag, "_wstrb_clr"}, m_wstrb, 0);
    chk({tag, "_i_ready"}, i_ready, !e.is_d);
    chk({tag, "_d_ready"}, d_ready, e.is_d);
    chk({tag, "_i_rdata"}, i_rdata, i_rd_exp);
    chk({tag, "_d_rdata"}, d_rdata, d_rd_exp);
    if (e.is_d) d_valid = 1'b0; else i_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_rdy_clear"}, {i_ready, d_ready}, 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    i_rd_exp = '0; d_rd_exp = '0;
  endtask

  initial begin
    resetn = 1'b0;
    i_valid = 0; i_addr = 0; i_wdata = 0; i_wstrb = 0;
    d_valid = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    m_ready = 0; m_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_m_wstrb", m_wstrb, 0);
    chk("rst_readies", {i_ready, d_ready}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    resetn = 1'b1;
    @(negedge clk);

    push_i(32'h100, 32'h0000_0013);
    serve("fetch", 0, 0);

    push_d(32'h2004, 32'hDEAD_BEEF, 4'hF, 32'h5555_AAAA);
    serve("store", 3, 0);

    do_reset();
    push_d(32'h20, 32'h0, 4'h0, 32'hD000_0001);
    push_i(32'h10, 32'h1000_0001);
    serve("tie1_d", 0, 0);
    serve("tie1_i", 0, 0);
    push_d(32'h20, 32'h0, 4'h0, 32'hD000_0002);
    push_i(32'h10, 32'h1000_0002);
    serve("tie2_d", 0, 0);
    serve("tie2_i", 0, 0);

    push_d(32'h20, 32'h0, 4'h0, 32'hD000_0010);
    push_i(32'h10, 32'h1000_0010);
    for (int k = 0; k < 4; k++) begin
      serve($sformatf("b2b%0d", k), 1, 0);
      if (k == 0) push_d(32'h20, 32'h0, 4'h0, 32'hD000_0011);
      if (k == 1) push_i(32'h10, 32'h1000_0011);
    end

    for (int k = 0; k < 2; k++) begin
      m_ready = 1'b1; m_rdata = 32'hBAD0_0000;
      @(negedge clk);
      chk("spur_ready", {i_ready, d_ready}, 0);
      chk("spur_mvalid", m_valid, 0);
    end
    m_ready = 1'b0;
    @(negedge clk);
    chk("spur_i_rdata", i_rdata, i_rd_exp);
    chk("spur_d_rdata", d_rdata, d_rd_exp);

    push_d(32'h300, 32'h1234_5678, 4'h3, 32'h0BAD_CAFE);
    serve("late", 2, 1);

    push_i(32'h400, 32'h7777_7777);
    @(negedge clk);
    chk("arst_grant", m_valid, 1);
    sb.delete();
    #2 resetn = 1'b0;
    #1;
    chk("arst_mvalid", m_valid, 0);
    chk("arst_readies", {i_ready, d_ready}, 0);
    i_rd_exp = '0; d_rd_exp = '0;
    chk("arst_i_rdata", i_rdata, 0);
    m_ready = 1'b1;
    @(negedge clk);
    chk("arst_hold_ready", {i_ready, d_ready}, 0);
    m_ready = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    push_i(32'h400, 32'h7777_7777);
    serve("post_rst", 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
